if_id_hazard_ctrl: RTL and testbench
====================================

IF_ID_HAZARD_CTRL -- requirements
Module: if_id_hazard_ctrl

Interface
REQ-001 Parameter PC_W, default 10, width of NPC/branch target (matches IF_ID NPC path).
REQ-002 Parameter CNT_W, default 16, width of performance counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-005 rs_id, rt_id  in  5 each  source register numbers of the instruction in IF_ID.
REQ-006 uses_rs, uses_rt  in  1 each  instruction in IF_ID actually reads rs / rt.
REQ-007 ex_mem_read  in  1  instruction in ID_EX is a load.
REQ-008 ex_rd  in  5  destination register of the instruction in ID_EX.
REQ-009 ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-010 ex_branch_target  in  PC_W  resolved target, valid with ex_branch_taken.
REQ-011 mc_start  in  1  multi-cycle op (mul/div) enters EX this cycle; mc_done  in  1  result ready.
REQ-012 pc_we, if_id_we  out  1 each  write enables for PC and IF_ID.
REQ-013 if_id_flush  out  1  IF_ID loads a NOP (instOut=0) at next edge.
REQ-014 id_ex_bubble  out  1  ID_EX loads a NOP at next edge.
REQ-015 pc_sel  out  1  0 = sequential NPC, 1 = pc_target; pc_target  out  PC_W.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-017 FSM states: RUN, MC_WAIT, MC_WAIT_BR; outputs combinational from state and inputs.
REQ-018 Load-use hazard = ex_mem_read & ex_rd!=0 & ((uses_rs & rs_id==ex_rd) | (uses_rt & rt_id==ex_rd)); register 0 never hazards.
REQ-019 RUN, no event: pc_we=1, if_id_we=1, flush=0, bubble=0, pc_sel=0.
REQ-020 RUN, ex_branch_taken: pc_sel=1, pc_target=ex_branch_target, pc_we=1, if_id_flush=1, id_ex_bubble=1; stay RUN; 2-cycle penalty.
REQ-021 RUN, load-use (no branch): pc_we=0, if_id_we=0, id_ex_bubble=1 for exactly that cycle; stay RUN (hazard clears as load advances).
REQ-022 RUN, mc_start (no branch): next state MC_WAIT; in MC_WAIT pc_we=0, if_id_we=0, id_ex_bubble=0, flush=0 until mc_done.
REQ-023 MC_WAIT & mc_done: release same cycle (RUN outputs), next state RUN.
REQ-024 ex_branch_taken while MC_WAIT: latch target into a PC_W register, go MC_WAIT_BR; held branch is not lost.
REQ-025 MC_WAIT_BR & mc_done: apply latched branch as REQ-020 (pc_sel=1, flush, bubble), next state RUN.
REQ-026 Priority in RUN: branch > mc_start > load-use; branch with simultaneous load-use flushes, no stall.
REQ-027 mc_start and mc_done same cycle in RUN: treated as single-cycle op, stay RUN.
REQ-028 stall_cnt +1 each cycle pc_we=0; flush_cnt +1 each cycle if_id_flush=1; both saturate at all-ones, never wrap.

Reset
REQ-029 reset=0: state=RUN, latched target=0, stall_cnt=0, flush_cnt=0, asynchronously.
REQ-030 During reset outputs: pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1, pc_sel=0, pc_target=0.
REQ-031 Reset asserted mid-MC_WAIT/MC_WAIT_BR aborts wait and discards latched branch; first cycle after release behaves as RUN.

Structure
REQ-032 Shared package holds state encoding (2-bit: RUN=0, MC_WAIT=1, MC_WAIT_BR=2), REG_W=5, PC_W/CNT_W defaults, NOP encoding 32'd0.
REQ-033 One sub-module sat_counter (width param, inc, clk, reset) instantiated twice for stall_cnt and flush_cnt.
REQ-034 State 3 unreachable; if entered, return to RUN next edge.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rd=5, rs_id=5, uses_rs=1 -> one cycle pc_we=0, if_id_we=0, id_ex_bubble=1; stall_cnt=1.
REQ-036 Reg-0: ex_mem_read=1, ex_rd=0, rs_id=0 -> no stall, pc_we=1.
REQ-037 Branch: ex_branch_taken=1, target=10'd50 -> same cycle pc_sel=1, pc_target=50, if_id_flush=1, id_ex_bubble=1; flush_cnt=1.
REQ-038 Multi-cycle: mc_start, mc_done 4 cycles later -> pc_we=0 for 4 cycles, stall_cnt=4, RUN after.
REQ-039 Branch in wait: mc_start, branch target=10'd10 on 2nd wait cycle, mc_done 3 cycles later -> pc_sel=1, pc_target=10 on mc_done cycle only.
REQ-040 Reset mid-wait, then saturation: reset=0 in MC_WAIT -> counters 0, RUN; forced 2^CNT_W+3 stall cycles -> stall_cnt=all-ones.

Source files
------------

// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard controller: state encoding, widths
// and the load-use hazard test used by the control FSM.
package if_id_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MC_WAIT    = 2'd1,
        ST_MC_WAIT_BR = 2'd2,
        ST_ILLEGAL    = 2'd3
    } hz_state_e;

    localparam int          REG_W       = 5;
    localparam int          PC_W_DEF    = 10;
    localparam int          CNT_W_DEF   = 16;
    localparam logic [31:0] NOP_INSTR   = 32'd0;

    // Register 0 is hardwired to zero, so a load targeting it can never hazard.
    function automatic logic load_use_hazard(
        input logic             mem_read,
        input logic [REG_W-1:0] rd,
        input logic             use_rs,
        input logic [REG_W-1:0] rs,
        input logic             use_rt,
        input logic [REG_W-1:0] rt
    );
        logic match_rs;
        logic match_rt;
        match_rs = use_rs && (rs == rd);
        match_rt = use_rt && (rt == rd);
        return mem_read && (rd != {REG_W{1'b0}}) && (match_rs || match_rt);
    endfunction

endpackage

// File: rtl/if_id_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface if_id_hazard_ctrl_if
    import if_id_hazard_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             uses_rs;
    logic             uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic [PC_W-1:0]  ex_branch_target;
    logic             mc_start;
    logic             mc_done;

    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pc_sel;
    logic [PC_W-1:0]  pc_target;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs_id, rt_id, uses_rs, uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, ex_branch_target, mc_start, mc_done,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble, pc_sel, pc_target,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_id, rt_id, uses_rs, uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, ex_branch_target, mc_start, mc_done,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble, pc_sel, pc_target,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/if_id_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register, held once it reaches all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle (mul/div) waits, with a branch held across the wait.
module if_id_hazard_ctrl
    import if_id_hazard_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic               clk,
    input logic               reset,
    if_id_hazard_ctrl_if.slave hz
);

    hz_state_e       state_r;
    hz_state_e       state_nx;
    logic [PC_W-1:0] br_tgt_r;
    logic [PC_W-1:0] br_tgt_nx;

    logic            hazard_s;
    logic            pc_we_s;
    logic            if_id_we_s;
    logic            flush_s;
    logic            bubble_s;
    logic            pc_sel_s;
    logic [PC_W-1:0] pc_target_s;

    assign hazard_s = load_use_hazard(hz.ex_mem_read, hz.ex_rd,
                                      hz.uses_rs, hz.rs_id,
                                      hz.uses_rt, hz.rt_id);

    // State and held-branch-target registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RUN;
            br_tgt_r <= {PC_W{1'b0}};
        end else begin
            state_r  <= state_nx;
            br_tgt_r <= br_tgt_nx;
        end
    end

    // Next-state and control decode; branch beats mc_start beats load-use.
    always_comb begin
        state_nx    = state_r;
        br_tgt_nx   = br_tgt_r;
        pc_we_s     = 1'b1;
        if_id_we_s  = 1'b1;
        flush_s     = 1'b0;
        bubble_s    = 1'b0;
        pc_sel_s    = 1'b0;
        pc_target_s = {PC_W{1'b0}};
        case (state_r)
            ST_RUN: begin
                if (hz.ex_branch_taken) begin
                    pc_sel_s    = 1'b1;
                    pc_target_s = hz.ex_branch_target;
                    flush_s     = 1'b1;
                    bubble_s    = 1'b1;
                end else if (hz.mc_start && !hz.mc_done) begin
                    pc_we_s    = 1'b0;
                    if_id_we_s = 1'b0;
                    state_nx   = ST_MC_WAIT;
                end else if (hazard_s) begin
                    pc_we_s    = 1'b0;
                    if_id_we_s = 1'b0;
                    bubble_s   = 1'b1;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_MC_WAIT: begin
                if (hz.mc_done) begin
                    state_nx = ST_RUN;
                    if (hz.ex_branch_taken) begin
                        pc_sel_s    = 1'b1;
                        pc_target_s = hz.ex_branch_target;
                        flush_s     = 1'b1;
                        bubble_s    = 1'b1;
                    end else begin
                        pc_sel_s = 1'b0;
                    end
                end else if (hz.ex_branch_taken) begin
                    pc_we_s    = 1'b0;
                    if_id_we_s = 1'b0;
                    br_tgt_nx  = hz.ex_branch_target;
                    state_nx   = ST_MC_WAIT_BR;
                end else begin
                    pc_we_s    = 1'b0;
                    if_id_we_s = 1'b0;
                end
            end
            ST_MC_WAIT_BR: begin
                // A second branch during the wait cannot displace the first one.
                if (hz.mc_done) begin
                    pc_sel_s    = 1'b1;
                    pc_target_s = br_tgt_r;
                    flush_s     = 1'b1;
                    bubble_s    = 1'b1;
                    state_nx    = ST_RUN;
                end else begin
                    pc_we_s    = 1'b0;
                    if_id_we_s = 1'b0;
                end
            end
            default: begin
                pc_we_s    = 1'b0;
                if_id_we_s = 1'b0;
                bubble_s   = 1'b1;
                state_nx   = ST_RUN;
            end
        endcase
    end

    // While reset is low the pipeline is frozen and fed NOPs.
    always_comb begin
        if (!reset) begin
            hz.pc_we        = 1'b0;
            hz.if_id_we     = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
            hz.pc_sel       = 1'b0;
            hz.pc_target    = {PC_W{1'b0}};
        end else begin
            hz.pc_we        = pc_we_s;
            hz.if_id_we     = if_id_we_s;
            hz.if_id_flush  = flush_s;
            hz.id_ex_bubble = bubble_s;
            hz.pc_sel       = pc_sel_s;
            hz.pc_target    = pc_target_s;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~hz.pc_we),
        .count (hz.stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hz.if_id_flush),
        .count (hz.flush_cnt)
    );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed self-checking bench for if_id_hazard_ctrl; inputs change on the
// falling edge, combinational outputs are checked 1 time unit later.
module tb_if_id_hazard_ctrl;

    localparam int PC_W  = 10;
    localparam int CNT_W = 8;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    if_id_hazard_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) hz ();

    if_id_hazard_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hz.rs_id            = 5'd0;
        hz.rt_id            = 5'd0;
        hz.uses_rs          = 1'b0;
        hz.uses_rt          = 1'b0;
        hz.ex_mem_read      = 1'b0;
        hz.ex_rd            = 5'd0;
        hz.ex_branch_taken  = 1'b0;
        hz.ex_branch_target = 10'd0;
        hz.mc_start         = 1'b0;
        hz.mc_done          = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    task automatic chk_ctl(input string tag, input logic pc_we, input logic if_id_we,
                           input logic flush, input logic bubble, input logic pc_sel,
                           input logic [9:0] tgt);
        #1;
        chk({tag, ".pc_we"},    {31'd0, hz.pc_we},        {31'd0, pc_we});
        chk({tag, ".if_id_we"}, {31'd0, hz.if_id_we},     {31'd0, if_id_we});
        chk({tag, ".flush"},    {31'd0, hz.if_id_flush},  {31'd0, flush});
        chk({tag, ".bubble"},   {31'd0, hz.id_ex_bubble}, {31'd0, bubble});
        chk({tag, ".pc_sel"},   {31'd0, hz.pc_sel},       {31'd0, pc_sel});
        chk({tag, ".pc_tgt"},   {22'd0, hz.pc_target},    {22'd0, tgt});
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] st, input logic [7:0] fl);
        chk({tag, ".stall_cnt"}, {24'd0, hz.stall_cnt}, {24'd0, st});
        chk({tag, ".flush_cnt"}, {24'd0, hz.flush_cnt}, {24'd0, fl});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle();
        // Branch request during reset must not reach pc_target.
        hz.ex_branch_taken  = 1'b1;
        hz.ex_branch_target = 10'd77;
        #1;
        chk_ctl("reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0);
        chk_cnt("reset", 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle();

        chk_ctl("run_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);

        next_cycle();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.rs_id = 5'd5; hz.uses_rs = 1'b1;
        chk_ctl("load_use_rs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);

        next_cycle();
        chk_ctl("after_load_use", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        chk_cnt("after_load_use", 8'd1, 8'd0);

        next_cycle();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.rs_id = 5'd0; hz.uses_rs = 1'b1;
        chk_ctl("reg0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);

        next_cycle();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.rt_id = 5'd7; hz.uses_rt = 1'b0;
        chk_ctl("rt_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);

        next_cycle();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.rt_id = 5'd7; hz.uses_rt = 1'b1;
        chk_ctl("load_use_rt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);

        next_cycle();
        hz.ex_branch_taken = 1'b1; hz.ex_branch_target = 10'd50;
        chk_ctl("branch50", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd50);
        chk_cnt("before_branch_edge", 8'd2, 8'd0);

        next_cycle();
        hz.ex_branch_taken = 1'b1; hz.ex_branch_target = 10'd20;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3; hz.rs_id = 5'd3; hz.uses_rs = 1'b1;
        chk_ctl("branch_over_load_use", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd20);
        chk_cnt("after_branch50", 8'd2, 8'd1);

        // Multi-cycle op: start, three plain wait cycles, done.
        next_cycle();
        hz.mc_start = 1'b1;
        chk_ctl("mc_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk_ctl("mc_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        end
        next_cycle();
        hz.mc_done = 1'b1;
        chk_ctl("mc_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        next_cycle();
        chk_ctl("mc_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        chk_cnt("mc_after", 8'd6, 8'd2);

        next_cycle();
        hz.mc_start = 1'b1; hz.mc_done = 1'b1;
        chk_ctl("mc_single", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        next_cycle();
        chk_ctl("mc_single_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);

        // Branch taken on the second wait cycle is held until mc_done.
        next_cycle();
        hz.mc_start = 1'b1;
        chk_ctl("mcbr_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        next_cycle();
        chk_ctl("mcbr_wait1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        next_cycle();
        hz.ex_branch_taken = 1'b1; hz.ex_branch_target = 10'd10;
        chk_ctl("mcbr_branch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        next_cycle();
        chk_ctl("mcbr_hold1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        next_cycle();
        chk_ctl("mcbr_hold2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        next_cycle();
        hz.mc_done = 1'b1;
        chk_ctl("mcbr_done", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd10);
        next_cycle();
        chk_ctl("mcbr_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        chk_cnt("mcbr_after", 8'd11, 8'd3);

        // Reset in MC_WAIT_BR discards the held branch.
        next_cycle();
        hz.mc_start = 1'b1;
        next_cycle();
        hz.ex_branch_taken = 1'b1; hz.ex_branch_target = 10'd99;
        next_cycle();
        #2;
        reset = 1'b0;
        chk_ctl("reset_mid_wait", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0);
        chk_cnt("reset_mid_wait", 8'd0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        idle();
        hz.mc_done = 1'b1;
        chk_ctl("post_reset_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        next_cycle();
        chk_ctl("post_reset_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        chk_cnt("post_reset_idle", 8'd0, 8'd0);

        // Force 2^CNT_W+3 stall cycles to hit saturation.
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            next_cycle();
            hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd9; hz.rs_id = 5'd9; hz.uses_rs = 1'b1;
        end
        next_cycle();
        #1;
        chk_cnt("saturate", 8'hFF, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
